// File: rtl/ssdisp_scan_if.sv
// ssdisp_scan_if
//   Bundles the load-side inputs and display-side outputs of the seven-segment
//   scan controller.
//   master : drives value_in/mask_in/load, observes the display outputs
//   slave  : the scan controller itself
//   value_in   [4*NUM_DIGITS] digit nibbles, digit 0 in bits [3:0]
//   mask_in    [NUM_DIGITS]   per-digit enable, captured with value_in
//   load                      single-cycle capture strobe
//   nib_out    [4]            nibble for the shared hex-to-segment decoder
//   nib_en                    decoder enable (0 blanks the segments)
//   dig_sel    [NUM_DIGITS]   one-hot digit select, all-zero while blanking
//   pending                   shadow holds data not yet displayed
//   frame_done                pulse on the last cycle of the last slot
interface ssdisp_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   mask_in;
    logic                    load;
    logic [3:0]              nib_out;
    logic                    nib_en;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    pending;
    logic                    frame_done;

    modport master (
        output value_in, mask_in, load,
        input  nib_out, nib_en, dig_sel, pending, frame_done
    );

    modport slave (
        input  value_in, mask_in, load,
        output nib_out, nib_en, dig_sel, pending, frame_done
    );
endinterface

// File: rtl/ssdisp_scan.sv
// ssdisp_scan
//   Time-multiplexed scan controller for a common-cathode seven-segment display.
//   Steps through NUM_DIGITS slots of DIV clocks each, presenting one digit's
//   nibble/enable to a shared decoder with a one-hot digit select. Loads go to a
//   shadow buffer and are copied to the displayed buffer only at the frame wrap,
//   so a frame never shows a mix of old and new data.
//   Ports: clk, nrst (async active-low), bus (ssdisp_scan_if.slave).
//   Optional feature: define SSDISP_BLANK_EN to make the first BLANK_CYCLES
//   clocks of every slot dead time (no digit selected) against ghosting.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_BLANK | slot dead time: dig_sel=0, nib_en=0, nib_out=0
//   ST_SHOW  | current digit selected, its nibble and mask bit presented
module ssdisp_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV          = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic          clk,
    input  logic          nrst,
    ssdisp_scan_if.slave  bus
);
    localparam int TW = $clog2(DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

`ifdef SSDISP_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    localparam logic [TW-1:0] TICK_LAST   = TW'(DIV - 1);
    localparam logic [TW-1:0] BLANK_TICKS = TW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DIG_LAST    = DW'(NUM_DIGITS - 1);
    // Tick 0 after reset is dead time only when blanking is built in.
    localparam state_t        RST_STATE   = BLANK_ON ? ST_BLANK : ST_SHOW;

    state_t                state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic [VW-1:0]         act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0] act_mask_q, act_mask_d;
    logic [VW-1:0]         shd_val_q, shd_val_d;
    logic [NUM_DIGITS-1:0] shd_mask_q, shd_mask_d;
    logic                  pend_q, pend_d;
    logic                  wrap;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= RST_STATE;
            tick_q     <= '0;
            digit_q    <= '0;
            act_val_q  <= '0;
            act_mask_q <= '0;
            shd_val_q  <= '0;
            shd_mask_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            digit_q    <= digit_d;
            act_val_q  <= act_val_d;
            act_mask_q <= act_mask_d;
            shd_val_q  <= shd_val_d;
            shd_mask_q <= shd_mask_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        tick_d     = tick_q + TW'(1);
        digit_d    = digit_q;
        act_val_d  = act_val_q;
        act_mask_d = act_mask_q;
        shd_val_d  = shd_val_q;
        shd_mask_d = shd_mask_q;
        pend_d     = pend_q;
        wrap       = (tick_q == TICK_LAST) && (digit_q == DIG_LAST);

        if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DW'(1);
        end

        if (bus.load && wrap) begin
            // Load coinciding with the wrap goes straight to the display so the
            // next frame already shows it; nothing is left pending.
            act_val_d  = bus.value_in;
            act_mask_d = bus.mask_in;
            shd_val_d  = bus.value_in;
            shd_mask_d = bus.mask_in;
            pend_d     = 1'b0;
        end else if (bus.load) begin
            shd_val_d  = bus.value_in;
            shd_mask_d = bus.mask_in;
            pend_d     = 1'b1;
        end else if (wrap && pend_q) begin
            act_val_d  = shd_val_q;
            act_mask_d = shd_mask_q;
            pend_d     = 1'b0;
        end

        // State follows the tick value it will be paired with next cycle.
        state_d = (BLANK_ON && (tick_d < BLANK_TICKS)) ? ST_BLANK : ST_SHOW;
    end

    always_comb begin
        bus.dig_sel    = '0;
        bus.nib_out    = 4'h0;
        bus.nib_en     = 1'b0;
        bus.frame_done = wrap;
        bus.pending    = pend_q;
        unique case (state_q)
            ST_BLANK: ;
            ST_SHOW: begin
                bus.dig_sel = NUM_DIGITS'(1) << digit_q;
                bus.nib_out = act_val_q[{digit_q, 2'b00} +: 4];
                bus.nib_en  = act_mask_q[digit_q];
            end
            default: ;
        endcase
    end
endmodule

// File: doc/ssdisp_scan.md
# ssdisp_scan

Time-multiplexed scan controller for a multi-digit common-cathode seven-segment display. Holds one 4-bit value per digit and steps through the digits at a programmable slot rate. Each slot presents the selected digit's nibble and enable to a single shared hex-to-segment decoder, and drives a one-hot digit select. Loads are double-buffered and applied only at frame boundaries, so a display update never tears mid-frame.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8)
- DIV, 1000, clk cycles per digit slot (>= 4)
- BLANK_CYCLES, 16, dead cycles at the start of each slot (1..DIV-2; used only with SSDISP_BLANK_EN)

- clk  in  1  system clock, all state on rising edge
- nrst  in  1  asynchronous active-low reset
- value_in  in  4*NUM_DIGITS  digit nibbles; digit i = value_in[4i+3:4i], digit 0 = rightmost
- mask_in  in  NUM_DIGITS  per-digit enable, sampled with value_in
- load  in  1  single-cycle strobe; captures value_in/mask_in
- nib_out  out  4  nibble for the shared decoder
- nib_en  out  1  decoder enable (0 blanks segments)
- dig_sel  out  NUM_DIGITS  one-hot active-high digit select, all-zero when blanking
- pending  out  1  shadow holds data not yet displayed
- frame_done  out  1  one-cycle pulse on the last cycle of the last slot

## Operation
- Registers: tick_cnt (0..DIV-1), digit_idx (0..NUM_DIGITS-1), shadow/active value+mask, pending.
- FSM states:
  - BLANK: tick_cnt < BLANK_CYCLES; dig_sel=0, nib_en=0, nib_out=0.
  - SHOW: all other slot cycles; dig_sel=1<<digit_idx, nib_out=active nibble[digit_idx], nib_en=active mask[digit_idx].
- Every cycle tick_cnt increments. At DIV-1 it returns to 0, and digit_idx advances.
- Wrap: digit_idx wraps NUM_DIGITS-1 -> 0. frame_done=1 on that wrap cycle only.
- load (not on a wrap cycle): shadow <= inputs, pending <= 1. Repeated loads overwrite the shadow; the last write wins.
- Wrap cycle with pending=1 and no load: active <= shadow, pending <= 0.
- load on the wrap cycle: active <= value_in/mask_in directly, shadow <= same values, and pending stays 0. Data is visible from digit 0 of the next frame.
- Masked digits still occupy their slot. dig_sel still asserts for them; only nib_en=0.
- Outputs decode combinationally from registered state only. There is no input-to-output combinational path.

## Timing
- Reset (async assert, sync-released state): tick_cnt=0, digit_idx=0, active=shadow=0, pending=0.
  - All outputs read 0 (frame_done=0, nib_en=0, dig_sel=0) during and after reset until the first SHOW cycle.
- Frame period is NUM_DIGITS*DIV cycles. frame_done is spaced exactly that far apart.
- Load-to-display latency: from 1 cycle up to 1 frame. New data appears at the first SHOW cycle of digit 0 after the next wrap.
- pending rises the cycle after load and falls the cycle after the wrap.
- A reset mid-frame immediately zeroes outputs. Scanning restarts at digit 0, tick 0, and all buffered data is discarded.

## Configuration
- SSDISP_BLANK_EN defined:
  - The first BLANK_CYCLES cycles of every slot are BLANK, giving anti-ghosting dead time between digit changes.
  - With DIV=8 and BLANK_CYCLES=2, slot cycles 0-1 are BLANK and 2-7 are SHOW.
- SSDISP_BLANK_EN undefined:
  - BLANK state and BLANK_CYCLES are unused, so the slot is SHOW for all DIV cycles.
  - Immediately after reset, dig_sel=1 with nib_en=0.

## Test plan
All scenarios use NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2, with SSDISP_BLANK_EN defined.
1. Reset:
   - Hold nrst low 5 cycles, then release.
   - Outputs all 0 during reset. Cycles 0-1 BLANK; cycle 2 gives dig_sel=4'b0001, nib_en=0.
   - frame_done first pulses at cycle 31.
2. Basic load:
   - Load 16'hA5C3, mask 4'b1111 at cycle 10.
   - pending=1 from cycle 11 to 32.
   - Next frame shows digit0=3, digit1=C, digit2=5, digit3=A. dig_sel follows 0001, 0010, 0100, 1000, each SHOW for 6 cycles.
3. Last write wins:
   - Load 16'h1111 at cycle 5, then 16'h2222 at cycle 20.
   - Only 2 is displayed next frame; 1 never appears on nib_out.
4. Load on the wrap cycle:
   - Assert load with 16'h4321 exactly on a frame_done cycle.
   - pending stays 0, and the next frame shows 1, 2, 3, 4.
5. Masking:
   - Load 16'h9999 with mask 4'b0101.
   - nib_en=1 only on digits 0 and 2. dig_sel still walks all four digits.
6. Reset mid-operation:
   - Drop nrst during the digit 2 SHOW state with pending=1.
   - Outputs go to 0 asynchronously and pending=0.
   - After release, the display scans from digit 0 with value 0, mask 0.
